// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC DRP sequencer and related blocks.
package xadc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Default DRP addresses of the auxiliary channels in round-robin order.
  localparam logic [6:0] VAUX1_ADDR = 7'h11;
  localparam logic [6:0] VAUX0_ADDR = 7'h10;
  localparam logic [6:0] VAUX8_ADDR = 7'h18;
  localparam logic [6:0] VAUX9_ADDR = 7'h19;

  localparam int NUM_SLOTS = 4;
  localparam int DATA_W    = 16;
  localparam int SLOT_W    = 2;

  // Round-robin successor; the two-bit slot wraps 3 -> 0 by itself.
  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] slot);
    return slot + 1'b1;
  endfunction

endpackage

// File: rtl/xadc_drp_sequencer_rate.sv
// Window counter plus saturating capture counter; publishes captures per window.
module rate_window_counter #(
  parameter int unsigned WINDOW_CYCLES = 100000000,
  parameter int unsigned RATE_W        = 24
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              capture_in,
  output logic [RATE_W-1:0] sample_rate_out
);

  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  logic [WIN_W-1:0]  win_q, win_d;
  logic [RATE_W-1:0] cap_q, cap_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [RATE_W-1:0] cap_inc;
  logic              wrap;

  // Next window position, saturating capture count, and end-of-window publish.
  always_comb begin
    wrap    = (win_q == WIN_LAST);
    cap_inc = (capture_in && (cap_q != '1)) ? cap_q + 1'b1 : cap_q;
    win_d   = wrap ? '0 : win_q + 1'b1;
    rate_d  = wrap ? cap_inc : rate_q;
    cap_d   = wrap ? '0 : cap_inc;
  end

  // Counter and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_q  <= '0;
      cap_q  <= '0;
      rate_q <= '0;
    end else begin
      win_q  <= win_d;
      cap_q  <= cap_d;
      rate_q <= rate_d;
    end
  end

  assign sample_rate_out = rate_q;

endmodule

// File: rtl/xadc_drp_sequencer.sv
// Reads the next auxiliary channel over DRP on each end-of-conversion and
// holds the latest result per slot; also reports captures per timing window.
module xadc_drp_sequencer
  import xadc_pkg::*;
#(
  parameter logic [6:0]  CH0_ADDR      = VAUX1_ADDR,
  parameter logic [6:0]  CH1_ADDR      = VAUX0_ADDR,
  parameter logic [6:0]  CH2_ADDR      = VAUX8_ADDR,
  parameter logic [6:0]  CH3_ADDR      = VAUX9_ADDR,
  parameter int unsigned TIMEOUT       = 63,
  parameter int unsigned WINDOW_CYCLES = 100000000,
  parameter int unsigned RATE_W        = 24
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          eoc_in,
  input  logic                          drdy_in,
  input  logic [DATA_W-1:0]             do_in,
  output logic [6:0]                    daddr_out,
  output logic                          den_out,
  output logic                          dwe_out,
  output logic [DATA_W-1:0]             di_out,
  output logic [NUM_SLOTS*DATA_W-1:0]   ch_data,
  output logic [NUM_SLOTS-1:0]          ch_valid,
  output logic [RATE_W-1:0]             sample_rate,
  output logic                          timeout_err,
  output logic                          overrun_err
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // WAIT lasts TIMEOUT cycles: the counter gives up once its next value would reach TIMEOUT.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e                        state_q, state_d;
  logic [SLOT_W-1:0]             slot_q, slot_d;
  logic [TMO_W-1:0]              tmo_q, tmo_d;
  logic [NUM_SLOTS*DATA_W-1:0]   ch_data_q, ch_data_d;
  logic [NUM_SLOTS-1:0]          ch_valid_q, ch_valid_d;
  logic                          timeout_err_q, timeout_err_d;
  logic                          overrun_err_q, overrun_err_d;
  logic                          capture;
  logic                          timeout_hit;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: one read in flight, ended by drdy or by the timeout.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (eoc_in) state_d = ST_REQ;
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: if (drdy_in || (tmo_q == TMO_LAST)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: den is the REQ state itself; address follows the current slot.
  always_comb begin
    den_out = (state_q == ST_REQ);
    dwe_out = 1'b0;
    di_out  = '0;
    unique case (slot_q)
      2'd0:    daddr_out = CH0_ADDR;
      2'd1:    daddr_out = CH1_ADDR;
      2'd2:    daddr_out = CH2_ADDR;
      default: daddr_out = CH3_ADDR;
    endcase
  end

  // Datapath next values: capture, slot advance, timeout counting, error flags.
  always_comb begin
    capture       = (state_q == ST_WAIT) && drdy_in;
    timeout_hit   = (state_q == ST_WAIT) && !drdy_in && (tmo_q == TMO_LAST);
    slot_d        = capture ? next_slot(slot_q) : slot_q;
    ch_data_d     = ch_data_q;
    ch_valid_d    = '0;
    tmo_d         = tmo_q;
    timeout_err_d = timeout_err_q | timeout_hit;
    overrun_err_d = overrun_err_q | (eoc_in && (state_q != ST_IDLE));
    if (state_q == ST_REQ) begin
      tmo_d = '0;
    end else if ((state_q == ST_WAIT) && !drdy_in) begin
      tmo_d = tmo_q + 1'b1;
    end
    if (capture) begin
      ch_data_d[slot_q*DATA_W +: DATA_W] = do_in;
      ch_valid_d[slot_q]                 = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_q        <= '0;
      tmo_q         <= '0;
      // NOTE: the holding registers are cleared too; downstream reads zero until a real sample lands.
      ch_data_q     <= '0;
      ch_valid_q    <= '0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      tmo_q         <= tmo_d;
      ch_data_q     <= ch_data_d;
      ch_valid_q    <= ch_valid_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign ch_data     = ch_data_q;
  assign ch_valid    = ch_valid_q;
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;

  rate_window_counter #(
    .WINDOW_CYCLES (WINDOW_CYCLES),
    .RATE_W        (RATE_W)
  ) u_rate (
    .clk             (clk),
    .rstn            (rstn),
    .capture_in      (capture),
    .sample_rate_out (sample_rate)
  );

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Scoreboard bench: reads push expected (slot, data); a negedge monitor pops on ch_valid.
module tb_xadc_drp_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        eoc = 1'b0;
  logic        drdy = 1'b0;
  logic [15:0] do_v = '0;

  logic [6:0]  daddr, daddr_s;
  logic        den, den_s, dwe, dwe_s;
  logic [15:0] di, di_s;
  logic [63:0] ch_data, ch_data_s;
  logic [3:0]  ch_valid, ch_valid_s;
  logic [23:0] rate;
  logic [3:0]  rate_s;
  logic        tmo_err, tmo_err_s, ovr_err, ovr_err_s;

  always #5 clk = ~clk;

  xadc_drp_sequencer #(.WINDOW_CYCLES(1000), .RATE_W(24)) dut (
    .clk(clk), .rstn(rstn), .eoc_in(eoc), .drdy_in(drdy), .do_in(do_v),
    .daddr_out(daddr), .den_out(den), .dwe_out(dwe), .di_out(di),
    .ch_data(ch_data), .ch_valid(ch_valid), .sample_rate(rate),
    .timeout_err(tmo_err), .overrun_err(ovr_err));

  // Same stimulus, narrow rate counter to exercise saturation.
  xadc_drp_sequencer #(.WINDOW_CYCLES(1000), .RATE_W(4)) dut_sat (
    .clk(clk), .rstn(rstn), .eoc_in(eoc), .drdy_in(drdy), .do_in(do_v),
    .daddr_out(daddr_s), .den_out(den_s), .dwe_out(dwe_s), .di_out(di_s),
    .ch_data(ch_data_s), .ch_valid(ch_valid_s), .sample_rate(rate_s),
    .timeout_err(tmo_err_s), .overrun_err(ovr_err_s));

  typedef struct {
    int          slot;
    logic [15:0] data;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   den_cnt = 0;
  int   exp_slot = 0;
  int   d0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] addr_of(input int s);
    case (s)
      0:       return 7'h11;
      1:       return 7'h10;
      2:       return 7'h18;
      default: return 7'h19;
    endcase
  endfunction

  // Monitor: counts den pulses and checks every capture against the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rstn) begin
      if (den) den_cnt++;
      if (ch_valid != 4'b0) begin
        if (q.size() == 0) begin
          check("unexpected_capture", 64'(ch_valid), 64'h0);
        end else begin
          e = q.pop_front();
          check("ch_valid", 64'(ch_valid), 64'(4'b1 << e.slot));
          check("ch_data_slot", 64'(ch_data[e.slot*16 +: 16]), 64'(e.data));
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    eoc = 1'b0;
    drdy = 1'b0;
    q.delete();
    exp_slot = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // One read: eoc, den next cycle, drdy dly cycles after den. Takes dly+3 clocks.
  task automatic do_read(input logic [15:0] data, input int dly);
    @(posedge clk); #1;
    check("daddr_pre", 64'(daddr), 64'(addr_of(exp_slot)));
    eoc = 1'b1;
    @(posedge clk); #1;
    eoc = 1'b0;
    check("den", 64'(den), 64'h1);
    repeat (dly) @(posedge clk);
    #1;
    drdy = 1'b1;
    do_v = data;
    q.push_back('{exp_slot, data});
    exp_slot = (exp_slot + 1) % 4;
    @(posedge clk); #1;
    drdy = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_daddr", 64'(daddr), 64'h11);
    check("rst_den", 64'(den), 64'h0);
    check("rst_ch_data", ch_data, 64'h0);
    check("rst_rate", 64'(rate), 64'h0);
    check("dwe_di", {47'h0, dwe, di}, 64'h0);
    do_reset();

    // Round robin over the four slots.
    do_read(16'h1230, 3);
    do_read(16'h4560, 3);
    do_read(16'h7890, 3);
    do_read(16'hABC0, 3);
    repeat (2) @(posedge clk);
    #1;
    check("ch_data_all", ch_data, 64'hABC0_7890_4560_1230);
    check("daddr_wrap", 64'(daddr), 64'h11);

    // Timeout: no drdy.
    @(posedge clk); #1 eoc = 1'b1;
    @(posedge clk); #1 eoc = 1'b0;
    check("tmo_den", 64'(den), 64'h1);
    repeat (62) @(posedge clk);
    #1 check("tmo_not_yet", 64'(tmo_err), 64'h0);
    repeat (4) @(posedge clk);
    #1;
    check("tmo_set", 64'(tmo_err), 64'h1);
    check("tmo_den_low", 64'(den), 64'h0);
    check("tmo_daddr", 64'(daddr), 64'h11);
    do_read(16'h0FF0, 3);
    repeat (2) @(posedge clk);
    #1 check("tmo_slot0", 64'(ch_data[15:0]), 64'h0FF0);

    // Overrun: second eoc while a slow read is outstanding.
    check("ovr_clear", 64'(ovr_err), 64'h0);
    d0 = den_cnt;
    @(posedge clk); #1 eoc = 1'b1;
    @(posedge clk); #1 eoc = 1'b0;
    repeat (2) @(posedge clk);
    #1 eoc = 1'b1;
    @(posedge clk); #1 eoc = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    drdy = 1'b1;
    do_v = 16'h5550;
    q.push_back('{exp_slot, 16'h5550});
    exp_slot = (exp_slot + 1) % 4;
    @(posedge clk); #1 drdy = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("ovr_set", 64'(ovr_err), 64'h1);
    check("ovr_one_den", 64'(den_cnt - d0), 64'h1);
    check("ovr_one_capture", 64'(q.size()), 64'h0);

    // Reset in the middle of a read, then a stray drdy.
    @(posedge clk); #1 eoc = 1'b1;
    @(posedge clk); #1 eoc = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    q.delete();
    exp_slot = 0;
    #1;
    check("mid_rst_daddr", 64'(daddr), 64'h11);
    check("mid_rst_den", 64'(den), 64'h0);
    check("mid_rst_data", ch_data, 64'h0);
    check("mid_rst_valid", 64'(ch_valid), 64'h0);
    check("mid_rst_flags", {62'h0, tmo_err, ovr_err}, 64'h0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    d0 = den_cnt;
    repeat (2) @(posedge clk);
    #1 drdy = 1'b1;
    do_v = 16'hDEA0;
    @(posedge clk); #1 drdy = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("stray_no_data", ch_data, 64'h0);
    check("stray_daddr", 64'(daddr), 64'h11);
    check("stray_no_den", 64'(den_cnt - d0), 64'h0);

    // Rate: one capture every 40 cycles -> 25 per 1000-cycle window.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      do_read(16'(i * 16), 3);
      repeat (34) @(posedge clk);
    end
    #1;
    check("rate40_first", 64'(rate), 64'd25);
    check("rate40_sat", 64'(rate_s), 64'd15);
    for (int i = 0; i < 50; i++) begin
      do_read(16'(i * 32), 3);
      repeat (34) @(posedge clk);
    end
    #1;
    check("rate40_stays", 64'(rate), 64'd25);
    check("rate40_sat_stays", 64'(rate_s), 64'd15);

    // Rate: one capture every 50 cycles -> 20 per window, 15 when 4 bits wide.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      do_read(16'(i * 48), 3);
      repeat (44) @(posedge clk);
    end
    #1;
    check("rate50", 64'(rate), 64'd20);
    check("rate50_sat", 64'(rate_s), 64'd15);

    repeat (5) @(posedge clk);
    #1 check("scoreboard_drained", 64'(q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
